// File: rtl/mem_bist_if.sv
// mem_bist_if: single-port RAM bus between the BIST engine and mem
interface mem_bist_if #(
  parameter int ADDR_WIDTH = 13,
  parameter int DATA_WIDTH = 64
);
  logic [ADDR_WIDTH-1:0] mem_address;
  logic [DATA_WIDTH-1:0] mem_data;
  logic                  mem_wren;
  logic [DATA_WIDTH-1:0] mem_q;
  modport master(output mem_address, mem_data, mem_wren, input mem_q);
  modport slave(input mem_address, mem_data, mem_wren, output mem_q);
endinterface

// File: rtl/mem_bist.sv
// mem_bist: write/read/compare of an address pattern and its inverse over the whole RAM
module mem_bist #(
  parameter int ADDR_WIDTH   = 13,
  parameter int DATA_WIDTH   = 64,
  parameter int LAST_ADDR    = 8191,
  parameter int READ_LATENCY = 1
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] seed,
  mem_bist_if.master            mem,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [15:0]           err_count,
  output logic [ADDR_WIDTH-1:0] first_err_addr,
  output logic [DATA_WIDTH-1:0] first_err_data
);
  typedef enum logic [2:0] {IDLE, WR0, RD0, DRN0, WR1, RD1, DRN1, DONE} state_t;
  state_t state, state_nxt;
  logic [ADDR_WIDTH-1:0] addr, addr_nxt;
  logic [DATA_WIDTH-1:0] seed_r, raw, pat;
  logic accept, rd, wr, drn, phase_end, miss;
  logic [READ_LATENCY-1:0] pv;
  logic [ADDR_WIDTH-1:0] pa [READ_LATENCY];
  logic [DATA_WIDTH-1:0] pd [READ_LATENCY];
  always_comb begin
    raw = seed_r ^ {DATA_WIDTH/16{16'(addr)}};
    pat = (state == WR1 || state == RD1) ? ~raw : raw;
    busy = !(state == IDLE || state == DONE);
    done = state == DONE;
    pass = done && err_count == 16'd0;
    accept = start && !busy;
    wr = state == WR0 || state == WR1;
    rd = state == RD0 || state == RD1;
    drn = state == DRN0 || state == DRN1;
    // the address counter doubles as the drain-cycle counter
    phase_end = drn ? addr == ADDR_WIDTH'(READ_LATENCY - 1) : addr == ADDR_WIDTH'(LAST_ADDR);
    miss = pv[READ_LATENCY-1] && mem.mem_q != pd[READ_LATENCY-1];
    state_nxt = state;
    addr_nxt = addr + ADDR_WIDTH'(1);
    if (!busy) begin
      state_nxt = accept ? WR0 : state;
      addr_nxt = '0;
    end else if (phase_end) begin
      state_nxt = state_t'(state + 3'd1);
      addr_nxt = '0;
    end
  end
  assign mem.mem_wren = wr;
  assign mem.mem_address = (wr || rd) ? addr : '0;
  assign mem.mem_data = wr ? pat : '0;
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      state <= IDLE;
      addr <= '0;
      seed_r <= '0;
      pv <= '0;
      err_count <= '0;
      first_err_addr <= '0;
      first_err_data <= '0;
    end else begin
      state <= state_nxt;
      addr <= addr_nxt;
      pv <= READ_LATENCY'({pv, rd});
      if (accept) begin
        seed_r <= seed;
        err_count <= '0;
        first_err_addr <= '0;
        first_err_data <= '0;
      end else if (miss) begin
        if (err_count != 16'hFFFF) err_count <= err_count + 16'd1;
        if (err_count == 16'd0) begin
          first_err_addr <= pa[READ_LATENCY-1];
          first_err_data <= mem.mem_q;
        end
      end
    end
  always_ff @(posedge clock) begin
    pa[0] <= addr;
    pd[0] <= pat;
    for (int i = 1; i < READ_LATENCY; i++) begin
      pa[i] <= pa[i-1];
      pd[i] <= pd[i-1];
    end
  end
endmodule

// File: tb/tb_mem_bist.sv
// tb_mem_bist: runs latency-1 and latency-2 engines side by side against fault-injecting RAM models
module tb_mem_bist;
  logic clock = 0, reset_n = 0, start = 0;
  logic [63:0] seed = '0;
  logic b1, d1, p1, b2, d2, p2;
  logic [15:0] e1, e2;
  logic [3:0] fa1, fa2;
  logic [63:0] fd1, fd2;
  logic [63:0] f0 [16], f1 [16];
  logic [63:0] ram1 [16], ram2 [16];
  logic [63:0] q1a, q2a, q2b;
  int n_cmp = 0, n_err = 0;
  mem_bist_if #(.ADDR_WIDTH(4), .DATA_WIDTH(64)) m1 ();
  mem_bist_if #(.ADDR_WIDTH(4), .DATA_WIDTH(64)) m2 ();
  mem_bist #(.ADDR_WIDTH(4), .DATA_WIDTH(64), .LAST_ADDR(15), .READ_LATENCY(1)) dut1 (
    .clock(clock), .reset_n(reset_n), .start(start), .seed(seed), .mem(m1),
    .busy(b1), .done(d1), .pass(p1), .err_count(e1), .first_err_addr(fa1), .first_err_data(fd1));
  mem_bist #(.ADDR_WIDTH(4), .DATA_WIDTH(64), .LAST_ADDR(15), .READ_LATENCY(2)) dut2 (
    .clock(clock), .reset_n(reset_n), .start(start), .seed(seed), .mem(m2),
    .busy(b2), .done(d2), .pass(p2), .err_count(e2), .first_err_addr(fa2), .first_err_data(fd2));
  always #5 clock = ~clock;
  always @(posedge clock) begin
    if (m1.mem_wren) ram1[m1.mem_address] <= m1.mem_data;
    q1a <= (ram1[m1.mem_address] & ~f0[m1.mem_address]) | f1[m1.mem_address];
    if (m2.mem_wren) ram2[m2.mem_address] <= m2.mem_data;
    q2a <= (ram2[m2.mem_address] & ~f0[m2.mem_address]) | f1[m2.mem_address];
    q2b <= q2a;
  end
  assign m1.mem_q = q1a;
  assign m2.mem_q = q2b;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] pat(input logic [63:0] s, input int a);
    return s ^ {4{16'(a)}};
  endfunction

  // every location is written then read once per pass; a fault only corrupts what is read back
  task automatic model(input logic [63:0] s, output int ne, output int fa, output logic [63:0] fd);
    logic [63:0] e, r;
    ne = 0; fa = 0; fd = '0;
    for (int p = 0; p < 2; p++)
      for (int a = 0; a < 16; a++) begin
        e = p == 1 ? ~pat(s, a) : pat(s, a);
        r = (e & ~f0[a]) | f1[a];
        if (r != e) begin
          if (ne == 0) begin fa = a; fd = r; end
          if (ne < 65535) ne++;
        end
      end
  endtask

  task automatic clear_faults();
    for (int a = 0; a < 16; a++) begin f0[a] = '0; f1[a] = '0; end
  endtask

  task automatic run(input logic [63:0] s, input bit hold);
    int nb1, nb2, cyc, ne, fa;
    logic [63:0] fd;
    logic [63:0] w1 [$], w2 [$];
    model(s, ne, fa, fd);
    seed = s;
    start = 1;
    @(negedge clock);
    start = hold;
    check("busy_k1", 64'(b1), 64'd1);
    check("done_k1", 64'(d1), 64'd0);
    check("err_k1", 64'(e1), 64'd0);
    check("busy2_k1", 64'(b2), 64'd1);
    nb1 = 0; nb2 = 0; cyc = 0;
    while ((b1 || b2) && cyc < 400) begin
      if (b1) nb1++;
      if (b2) nb2++;
      if (m1.mem_wren && m1.mem_address == 4'd3) w1.push_back(m1.mem_data);
      if (m2.mem_wren && m2.mem_address == 4'd3) w2.push_back(m2.mem_data);
      if (hold && (d1 || d2)) start = 0;
      @(negedge clock);
      cyc++;
    end
    start = 0;
    check("timeout", 64'(cyc < 400), 64'd1);
    check("busy_len1", 64'(nb1), 64'd66);
    check("busy_len2", 64'(nb2), 64'd68);
    check("done1", 64'(d1), 64'd1);
    check("done2", 64'(d2), 64'd1);
    check("err1", 64'(e1), 64'(ne));
    check("err2", 64'(e2), 64'(ne));
    check("pass1", 64'(p1), 64'(ne == 0));
    check("pass2", 64'(p2), 64'(ne == 0));
    check("faddr1", 64'(fa1), 64'(fa));
    check("faddr2", 64'(fa2), 64'(fa));
    check("fdata1", fd1, fd);
    check("fdata2", fd2, fd);
    check("wr3_cnt1", 64'(w1.size()), 64'd2);
    check("wr3_cnt2", 64'(w2.size()), 64'd2);
    if (w1.size() == 2) begin
      check("wr3_p0", w1[0], pat(s, 3));
      check("wr3_p1", w1[1], ~pat(s, 3));
    end
    if (w2.size() == 2) check("wr3_p1_l2", w2[1], ~pat(s, 3));
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_wren"}, 64'(m1.mem_wren), 64'd0);
    check({tag, "_addr"}, 64'(m1.mem_address), 64'd0);
    check({tag, "_data"}, m1.mem_data, 64'd0);
    check({tag, "_busy"}, 64'({b1, b2}), 64'd0);
    check({tag, "_done"}, 64'({d1, p1}), 64'd0);
    check({tag, "_err"}, 64'(e1), 64'd0);
    check({tag, "_first"}, 64'(fa1) | fd1, 64'd0);
    check({tag, "_wren2"}, 64'(m2.mem_wren), 64'd0);
  endtask

  initial begin
    clear_faults();
    repeat (2) @(negedge clock);
    check_reset("rst");
    reset_n = 1;
    @(negedge clock);
    run(64'd0, 0);
    check("clean_wr3_p0", pat(64'd0, 3), 64'h0003000300030003);
    f0[5] = 64'd1;
    run(64'd0, 0);
    clear_faults();
    run(64'hFFFF_FFFF_FFFF_FFFF, 0);
    seed = '0;
    start = 1;
    @(negedge clock);
    start = 0;
    repeat (19) @(negedge clock);
    check("pre_rst_busy", 64'(b1), 64'd1);
    reset_n = 0;
    #1;
    check_reset("midrst");
    @(negedge clock);
    reset_n = 1;
    @(negedge clock);
    run(64'd0, 0);
    run(64'd0, 1);
    f0[5] = 64'd1; f1[6] = 64'd1; f0[7] = 64'd1;
    run(64'd0, 0);
    check("three_err", 64'(e1), 64'd3);
    clear_faults();
    run(64'd0, 0);
    for (int it = 0; it < 6; it++) begin
      int a, b;
      clear_faults();
      repeat ($urandom_range(0, 3)) begin
        a = $urandom_range(0, 15);
        b = $urandom_range(0, 63);
        if ($urandom_range(0, 1) == 1) f0[a][b] = 1'b1;
        else f1[a][b] = 1'b1;
      end
      run({$urandom, $urandom}, 1'($urandom_range(0, 1)));
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
